// File: rtl/boton_eventos.sv
// Button event generator: turns the debounced push-button level into one-cycle
// short-press, long-press and auto-repeat command pulses on the system clock.
module boton_eventos #(
    parameter int CLK_DIV   = 50000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic reloja,
    input  logic resetn,
    input  logic arebote,
    output logic presionado,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_rep
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] PRESION = 2'd1;
    localparam logic [1:0] LARGO   = 2'd2;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [15:0]   LONG_LAST  = 16'(LONG_MS - 1);
    localparam logic [15:0]   REP_LAST   = 16'(REPEAT_MS - 1);

    logic          s1;
    logic          s;
    logic [1:0]    estado;
    logic [PW-1:0] presc;
    logic [15:0]   cuenta;
    logic          tick;
    logic          entrada;

    // arebote comes from a divided-clock domain, so it gets a two-flop synchroniser
    always_ff @(posedge reloja or negedge resetn) begin
        if (!resetn) begin
            s1         <= 1'b0;
            s          <= 1'b0;
            presionado <= 1'b0;
        end else begin
            s1         <= arebote;
            s          <= s1;
            presionado <= s;
        end
    end

    assign tick    = (presc == PRESC_MAX);
    assign entrada = (estado == REPOSO) && s;

    // Restarting the prescaler on each new press makes the first tick land exactly CLK_DIV cycles later
    always_ff @(posedge reloja or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (entrada || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge reloja or negedge resetn) begin
        if (!resetn) begin
            estado      <= REPOSO;
            cuenta      <= 16'd0;
            pulso_corto <= 1'b0;
            pulso_largo <= 1'b0;
            pulso_rep   <= 1'b0;
        end else begin
            pulso_corto <= 1'b0;
            pulso_largo <= 1'b0;
            pulso_rep   <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (s) begin
                        estado <= PRESION;
                        cuenta <= 16'd0;
                    end
                end
                // Release is tested first so it wins over a terminal tick in the same cycle
                PRESION: begin
                    if (!s) begin
                        pulso_corto <= 1'b1;
                        estado      <= REPOSO;
                        cuenta      <= 16'd0;
                    end else if (tick) begin
                        if (cuenta == LONG_LAST) begin
                            pulso_largo <= 1'b1;
                            estado      <= LARGO;
                            cuenta      <= 16'd0;
                        end else begin
                            cuenta <= cuenta + 16'd1;
                        end
                    end
                end
                LARGO: begin
                    if (!s) begin
                        estado <= REPOSO;
                        cuenta <= 16'd0;
                    end else if (tick) begin
                        if (cuenta == REP_LAST) begin
                            pulso_rep <= 1'b1;
                            cuenta    <= 16'd0;
                        end else begin
                            cuenta <= cuenta + 16'd1;
                        end
                    end
                end
                default: begin
                    estado <= REPOSO;
                    cuenta <= 16'd0;
                end
            endcase
        end
    end

endmodule
